// File: rtl/ram_arbiter.sv
// Two-master round-robin arbiter in front of a single-port synchronous RAM
// with one-cycle read latency. A registered command copy drives the RAM for
// exactly one ISSUE cycle; the completion is reported in the following RESP
// cycle, where the next pending request is also arbitrated.
module ram_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    m0_req,
    input  logic                    m0_we,
    input  logic [ADDR_WIDTH-1:0]   m0_addr,
    input  logic [DATA_WIDTH-1:0]   m0_wdata,
    input  logic [DATA_WIDTH/8-1:0] m0_be,
    output logic                    m0_gnt,
    output logic                    m0_rvalid,
    output logic [DATA_WIDTH-1:0]   m0_rdata,

    input  logic                    m1_req,
    input  logic                    m1_we,
    input  logic [ADDR_WIDTH-1:0]   m1_addr,
    input  logic [DATA_WIDTH-1:0]   m1_wdata,
    input  logic [DATA_WIDTH/8-1:0] m1_be,
    output logic                    m1_gnt,
    output logic                    m1_rvalid,
    output logic [DATA_WIDTH-1:0]   m1_rdata,

    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic                    ram_we,
    output logic                    ram_re,
    output logic [DATA_WIDTH/8-1:0] ram_be,
    output logic [DATA_WIDTH-1:0]   ram_wdata,
    input  logic [DATA_WIDTH-1:0]   ram_rdata
);

    localparam int BE_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic                   last_q, last_d;      // id of the most recently latched master
    logic                   id_q, id_d;          // owner of the command register
    logic                   we_q, we_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [BE_W-1:0]        be_q, be_d;
    logic [DATA_WIDTH-1:0]  rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0]  rdata1_q, rdata1_d;

    logic                   any_req;
    logic                   winner;
    logic                   latch;
    logic                   in_issue;
    logic                   in_resp;
    logic [DATA_WIDTH-1:0]  resp_data;

    // Round-robin pick: a lone requester wins; on contention the master that
    // did not win last time goes first, so the loser is always served next.
    always_comb begin
        any_req = m0_req | m1_req;
        winner  = (m0_req & m1_req) ? ~last_q : m1_req;
    end

    // Next-state and command-register load; arbitration happens in IDLE and RESP.
    always_comb begin
        state_d = state_q;
        latch   = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    latch   = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = RESP;
            RESP: begin
                if (any_req) begin
                    latch   = 1'b1;
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        last_d  = last_q;
        id_d    = id_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        if (latch) begin
            last_d  = winner;
            id_d    = winner;
            we_d    = winner ? m1_we    : m0_we;
            addr_d  = winner ? m1_addr  : m0_addr;
            wdata_d = winner ? m1_wdata : m0_wdata;
            be_d    = winner ? m1_be    : m0_be;
        end
    end

    // RAM command and master handshakes decode from the state register, so an
    // asynchronous reset kills the strobes without waiting for a clock edge.
    always_comb begin
        in_issue  = (state_q == ISSUE);
        in_resp   = (state_q == RESP);
        ram_we    = in_issue & we_q;
        ram_re    = in_issue & ~we_q;
        ram_be    = (in_issue & we_q) ? be_q : '0;
        ram_addr  = addr_q;
        ram_wdata = wdata_q;
        m0_gnt    = in_issue & ~id_q;
        m1_gnt    = in_issue & id_q;
        m0_rvalid = in_resp & ~id_q;
        m1_rvalid = in_resp & id_q;
    end

    // RAM data arrives during RESP; it is passed straight through alongside
    // rvalid and captured so each master's rdata holds until its next rvalid.
    always_comb begin
        resp_data = we_q ? '0 : ram_rdata;
        rdata0_d  = m0_rvalid ? resp_data : rdata0_q;
        rdata1_d  = m1_rvalid ? resp_data : rdata1_q;
        m0_rdata  = rdata0_d;
        m1_rdata  = rdata1_d;
    end

    // State, round-robin pointer, command register and held read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            id_q     <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            id_q     <= id_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios with exact cycle expectations,
// then randomized traffic checked against a memory scoreboard and the
// arbitration rules (one grant at a time, alternation under contention,
// bounded wait, completion one cycle after grant).
module tb_ram_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic clk = 1'b0;
    logic rst;
    logic mem_init;

    logic          req[2];
    logic          we[2];
    logic [AW-1:0] addr[2];
    logic [DW-1:0] wdata[2];
    logic [BW-1:0] be[2];
    logic          gnt[2];
    logic          rvalid[2];
    logic [DW-1:0] rdata[2];

    logic [AW-1:0] ram_addr;
    logic          ram_we, ram_re;
    logic [BW-1:0] ram_be;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    logic [31:0] mem[256];
    logic [31:0] ref_mem[256];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .m0_req(req[0]), .m0_we(we[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]), .m0_be(be[0]),
        .m0_gnt(gnt[0]), .m0_rvalid(rvalid[0]), .m0_rdata(rdata[0]),
        .m1_req(req[1]), .m1_we(we[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]), .m1_be(be[1]),
        .m1_gnt(gnt[1]), .m1_rvalid(rvalid[1]), .m1_rdata(rdata[1]),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_re(ram_re), .ram_be(ram_be),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    function automatic logic [31:0] init_word(input int i);
        if (i == 4) return 32'hDEADBEEF;
        if (i == 8) return 32'h11223344;
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // Synchronous single-port RAM, word indexed by byte address bits [9:2].
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else begin
            if (ram_we)
                for (int b = 0; b < BW; b++)
                    if (ram_be[b]) mem[ram_addr[9:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
            if (ram_re) ram_rdata <= mem[ram_addr[9:2]];
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_txn(input int n, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [BW-1:0] b);
        req[n] = 1'b1; we[n] = w; addr[n] = a; wdata[n] = d; be[n] = b;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) step;
        total++;
        if ({gnt[0], gnt[1], rvalid[0], rvalid[1], rdata[0], rdata[1], ram_we, ram_re,
             ram_be, ram_addr, ram_wdata} !== '0)
            $display("FAIL reset_outputs got gnt=%b%b rv=%b%b rd0=%h rd1=%h we=%b re=%b be=%h addr=%h wd=%h exp all 0",
                     gnt[0], gnt[1], rvalid[0], rvalid[1], rdata[0], rdata[1], ram_we, ram_re, ram_be, ram_addr, ram_wdata);
        rst = 1'b0; mem_init = 1'b0;
        step;
        total++;
        if ({gnt[0], gnt[1], rvalid[0], rvalid[1], ram_we, ram_re} !== '0) begin
            bad++;
            $display("FAIL post_reset_idle got gnt=%b%b rv=%b%b we=%b re=%b exp 0", gnt[0], gnt[1], rvalid[0], rvalid[1], ram_we, ram_re);
        end
    endtask

    // Two back-to-back contention rounds; master 0 must go first each time.
    task automatic test_contention;
        logic [31:0] e0, e1;
        for (int r = 0; r < 2; r++) begin
            set_txn(0, 1'b0, 32'h100 + 32'(r * 8), 32'h0, 4'hF);
            set_txn(1, 1'b0, 32'h104 + 32'(r * 8), 32'h0, 4'hF);
            e0 = ref_mem[64 + r * 2];
            e1 = ref_mem[65 + r * 2];
            step;
            total++;
            if ({gnt[0], gnt[1]} !== 2'b10) begin bad++; $display("FAIL cont_gnt0 round=%0d got=%b%b exp=10", r, gnt[0], gnt[1]); end
            req[0] = 1'b0;
            step;
            total++;
            if ({rvalid[0], rvalid[1], rdata[0]} !== {2'b10, e0}) begin
                bad++; $display("FAIL cont_rv0 round=%0d got rv=%b%b data=%h exp rv=10 data=%h", r, rvalid[0], rvalid[1], rdata[0], e0);
            end
            step;
            total++;
            if ({gnt[0], gnt[1]} !== 2'b01) begin bad++; $display("FAIL cont_gnt1 round=%0d got=%b%b exp=01", r, gnt[0], gnt[1]); end
            req[1] = 1'b0;
            step;
            total++;
            if ({rvalid[0], rvalid[1], rdata[1]} !== {2'b01, e1}) begin
                bad++; $display("FAIL cont_rv1 round=%0d got rv=%b%b data=%h exp rv=01 data=%h", r, rvalid[0], rvalid[1], rdata[1], e1);
            end
            step;
        end
    endtask

    task automatic test_single_read;
        set_txn(0, 1'b0, 32'h10, 32'h0, 4'hF);
        step;
        total++;
        if ({ram_re, ram_we, ram_addr, gnt[0], gnt[1]} !== {2'b10, 32'h10, 2'b10}) begin
            bad++; $display("FAIL read_issue got re=%b we=%b addr=%h gnt=%b%b exp re=1 we=0 addr=10 gnt=10", ram_re, ram_we, ram_addr, gnt[0], gnt[1]);
        end
        req[0] = 1'b0;
        step;
        total++;
        if ({rvalid[0], rdata[0], ram_re} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin
            bad++; $display("FAIL read_resp got rv=%b data=%h re=%b exp rv=1 data=deadbeef re=0", rvalid[0], rdata[0], ram_re);
        end
        step;
        total++;
        if ({rvalid[0], rdata[0]} !== {1'b0, 32'hDEADBEEF}) begin
            bad++; $display("FAIL read_hold got rv=%b data=%h exp rv=0 data=deadbeef", rvalid[0], rdata[0]);
        end
    endtask

    task automatic test_byte_write;
        set_txn(1, 1'b1, 32'h21, 32'h0000AB00, 4'b0010);
        ref_mem[8][15:8] = 8'hAB;
        step;
        total++;
        if ({ram_we, ram_re, ram_be, ram_wdata, gnt[1], gnt[0]} !== {2'b10, 4'b0010, 32'h0000AB00, 2'b10}) begin
            bad++; $display("FAIL write_issue got we=%b re=%b be=%b wd=%h gnt1=%b gnt0=%b", ram_we, ram_re, ram_be, ram_wdata, gnt[1], gnt[0]);
        end
        req[1] = 1'b0;
        step;
        total++;
        if ({rvalid[1], rdata[1], ram_we} !== {1'b1, 32'h0, 1'b0}) begin
            bad++; $display("FAIL write_resp got rv=%b data=%h we=%b exp rv=1 data=0 we=0", rvalid[1], rdata[1], ram_we);
        end
        step;
        set_txn(1, 1'b0, 32'h20, 32'h0, 4'hF);
        step;
        req[1] = 1'b0;
        step;
        total++;
        if ({rvalid[1], rdata[1]} !== {1'b1, 32'h1122AB44}) begin
            bad++; $display("FAIL write_readback got rv=%b data=%h exp rv=1 data=1122ab44", rvalid[1], rdata[1]);
        end
        step;
    endtask

    task automatic test_back_to_back;
        int k = 0;
        set_txn(0, 1'b0, 32'h200, 32'h0, 4'hF);
        for (int c = 1; c <= 8; c++) begin
            step;
            total++;
            if (gnt[0] !== (c % 2 == 1)) begin bad++; $display("FAIL b2b_gnt cycle=%0d got=%b exp=%b", c, gnt[0], (c % 2 == 1)); end
            total++;
            if (rvalid[0] !== (c % 2 == 0)) begin bad++; $display("FAIL b2b_rvalid cycle=%0d got=%b exp=%b", c, rvalid[0], (c % 2 == 0)); end
            if (c % 2 == 0) begin
                total++;
                if ({rdata[0], ram_re} !== {ref_mem[128 + c / 2 - 1], 1'b0}) begin
                    bad++; $display("FAIL b2b_resp cycle=%0d got data=%h re=%b exp data=%h re=0", c, rdata[0], ram_re, ref_mem[128 + c / 2 - 1]);
                end
            end
            if (gnt[0] === 1'b1) begin
                k++;
                if (k < 4) addr[0] = 32'h200 + 32'(4 * k);
                else req[0] = 1'b0;
            end
        end
        step;
    endtask

    task automatic test_idle;
        for (int c = 0; c < 10; c++) begin
            step;
            total++;
            if ({ram_we, ram_re, ram_be, gnt[0], gnt[1], rvalid[0], rvalid[1]} !== '0) begin
                bad++; $display("FAIL idle cycle=%0d got we=%b re=%b be=%h gnt=%b%b rv=%b%b exp 0", c, ram_we, ram_re, ram_be, gnt[0], gnt[1], rvalid[0], rvalid[1]);
            end
        end
    endtask

    task automatic test_reset_issue;
        set_txn(0, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF);
        step;
        total++;
        if (ram_we !== 1'b1) begin bad++; $display("FAIL rst_pre_we got=%b exp=1", ram_we); end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({ram_we, ram_re, ram_be, gnt[0], gnt[1]} !== '0) begin
            bad++; $display("FAIL rst_async got we=%b re=%b be=%h gnt=%b%b exp 0", ram_we, ram_re, ram_be, gnt[0], gnt[1]);
        end
        req[0] = 1'b0;
        for (int c = 0; c < 2; c++) begin
            step;
            total++;
            if ({rvalid[0], rvalid[1], ram_we, rdata[0], rdata[1]} !== '0) begin
                bad++; $display("FAIL rst_hold cycle=%0d got rv=%b%b we=%b rd0=%h rd1=%h exp 0", c, rvalid[0], rvalid[1], ram_we, rdata[0], rdata[1]);
            end
        end
        rst = 1'b0;
        set_txn(0, 1'b0, 32'h44, 32'h0, 4'hF);
        set_txn(1, 1'b0, 32'h40, 32'h0, 4'hF);
        step;
        total++;
        if ({gnt[0], gnt[1]} !== 2'b10) begin bad++; $display("FAIL rst_rr_gnt0 got=%b%b exp=10", gnt[0], gnt[1]); end
        req[0] = 1'b0;
        step;
        step;
        total++;
        if ({gnt[0], gnt[1]} !== 2'b01) begin bad++; $display("FAIL rst_rr_gnt1 got=%b%b exp=01", gnt[0], gnt[1]); end
        req[1] = 1'b0;
        step;
        total++;
        if ({rvalid[1], rdata[1]} !== {1'b1, ref_mem[16]}) begin
            bad++; $display("FAIL rst_dropped_write got rv=%b data=%h exp rv=1 data=%h", rvalid[1], rdata[1], ref_mem[16]);
        end
        step;
    endtask

    task automatic new_txn(input int n);
        set_txn(n, 1'($urandom % 2), 32'($urandom_range(0, 1023)), $urandom, 4'($urandom));
    endtask

    task automatic test_random;
        int          wait_cnt[2];
        bit          pend[2];
        logic [31:0] exp_rd[2];
        int          last_g = -1;
        bit          both;
        logic [BW-1:0] exp_be;
        wait_cnt[0] = 0; wait_cnt[1] = 0; pend[0] = 0; pend[1] = 0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        for (int c = 0; c < 404; c++) begin
            step;
            both = req[0] && req[1];
            total++;
            if ((gnt[0] & gnt[1]) !== 1'b0) begin bad++; $display("FAIL rnd_dual_gnt cycle=%0d got=%b%b exp one-hot", c, gnt[0], gnt[1]); end
            total++;
            if ((rvalid[0] & rvalid[1]) !== 1'b0) begin bad++; $display("FAIL rnd_dual_rvalid cycle=%0d got=%b%b exp one-hot", c, rvalid[0], rvalid[1]); end
            for (int n = 0; n < 2; n++) begin
                total++;
                if (rvalid[n] !== pend[n]) begin bad++; $display("FAIL rnd_rvalid m%0d cycle=%0d got=%b exp=%b", n, c, rvalid[n], pend[n]); end
                if (pend[n]) begin
                    total++;
                    if (rdata[n] !== exp_rd[n]) begin bad++; $display("FAIL rnd_rdata m%0d cycle=%0d got=%h exp=%h", n, c, rdata[n], exp_rd[n]); end
                end
                pend[n] = 1'b0;
            end
            for (int n = 0; n < 2; n++) begin
                if (gnt[n] === 1'b1) begin
                    exp_be = we[n] ? be[n] : '0;
                    total++;
                    if ({req[n], ram_we, ram_re, ram_be, ram_addr, ram_wdata} !== {1'b1, we[n], ~we[n], exp_be, addr[n], wdata[n]}) begin
                        bad++; $display("FAIL rnd_cmd m%0d cycle=%0d got req=%b we=%b re=%b be=%h addr=%h wd=%h exp req=1 we=%b be=%h addr=%h wd=%h",
                                        n, c, req[n], ram_we, ram_re, ram_be, ram_addr, ram_wdata, we[n], exp_be, addr[n], wdata[n]);
                    end
                    if (both && last_g >= 0) begin
                        total++;
                        if (n == last_g) begin bad++; $display("FAIL rnd_round_robin cycle=%0d got winner=%0d exp=%0d", c, n, 1 - n); end
                    end
                    last_g = n;
                    wait_cnt[n] = 0;
                    pend[n] = 1'b1;
                    if (we[n]) begin
                        for (int b = 0; b < BW; b++)
                            if (be[n][b]) ref_mem[addr[n][9:2]][8*b +: 8] = wdata[n][8*b +: 8];
                        exp_rd[n] = '0;
                    end else begin
                        exp_rd[n] = ref_mem[addr[n][9:2]];
                    end
                end else if (req[n]) begin
                    wait_cnt[n]++;
                    total++;
                    if (wait_cnt[n] > 3) begin bad++; $display("FAIL rnd_wait m%0d cycle=%0d got wait=%0d exp<=3", n, c, wait_cnt[n]); end
                end
            end
            for (int n = 0; n < 2; n++) begin
                if (gnt[n] === 1'b1) begin
                    if (c < 400 && $urandom % 3 == 0) new_txn(n);
                    else req[n] = 1'b0;
                end else if (!req[n] && c < 400 && $urandom % 2 == 0) begin
                    new_txn(n);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        mem_init = 1'b1;
        for (int n = 0; n < 2; n++) begin
            req[n] = 1'b0; we[n] = 1'b0; addr[n] = '0; wdata[n] = '0; be[n] = '0;
        end
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        test_reset;
        test_contention;
        test_single_read;
        test_byte_write;
        test_back_to_back;
        test_idle;
        test_reset_issue;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-master arbiter sharing one single-port synchronous data RAM (1-cycle read latency) between the CPU data port (master 0) and a loader/debug port (master 1). Each master issues a request and holds it until granted. The arbiter picks a winner round-robin and drives one RAM command from a registered copy of the winner's request. The returned read data is captured and presented with a one-cycle valid pulse. It sits between the core's memory interface and the RAM instance.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- mN_req  in  1  request, N in {0,1}; held with fields stable until mN_gnt
- mN_we  in  1  1 = write, 0 = read
- mN_addr  in  ADDR_WIDTH  byte address, forwarded unmodified (no alignment/shift)
- mN_wdata  in  DATA_WIDTH  write data, already lane-shifted by master
- mN_be  in  DATA_WIDTH/8  byte enables
- mN_gnt  out  1  one-cycle pulse: request accepted, RAM command issued this cycle
- mN_rvalid  out  1  one-cycle completion pulse (reads and writes)
- mN_rdata  out  DATA_WIDTH  read data, valid with mN_rvalid
- ram_addr  out  ADDR_WIDTH  RAM address
- ram_we  out  1  RAM write strobe
- ram_re  out  1  RAM read strobe
- ram_be  out  DATA_WIDTH/8  RAM byte enables
- ram_wdata  out  DATA_WIDTH  RAM write data
- ram_rdata  in  DATA_WIDTH  RAM read data, valid the cycle after ram_re

## Operation
- States: IDLE, ISSUE, RESP.
- IDLE: if any req is high, arbitrate, latch the winner's we/addr/wdata/be and the winner id into the command register, then go to ISSUE. Otherwise stay in IDLE.
- ISSUE:
  - Drive ram_* from the command register.
  - ram_re = ~we; ram_we = we; ram_be = be for writes, 0 for reads.
  - Pulse gnt to the winner.
  - Always go to RESP.
- RESP:
  - Pulse rvalid to the winner.
  - rdata = ram_rdata registered for reads, 0 for writes.
  - In the same cycle, arbitrate pending reqs: on any req, latch the new winner and go to ISSUE; else go to IDLE.
- Round-robin: a 1-bit last_grant register, updated at each latch.
  - One requester: it wins.
  - Both requesting: the master ≠ last_grant wins.
- Masters deassert req the cycle after gnt unless they present a new transaction. A req still high in RESP is treated as a new transaction.
- Outside ISSUE: ram_we=0, ram_re=0, ram_be=0. ram_addr and ram_wdata hold the last command value.
- mN_rdata holds its value until the next rvalid to that master.

## Timing
- Reset values:
  - state=IDLE, last_grant=1 (master 0 wins the first contention).
  - All gnt/rvalid 0, all rdata 0.
  - ram_we=0, ram_re=0, ram_be=0, ram_addr=0, ram_wdata=0.
- Latency: req sampled high in IDLE at edge k gives gnt/ISSUE in cycle k+1 and rvalid/data in cycle k+2.
- Throughput: one transaction per 2 cycles when requests stay pending (RESP→ISSUE directly).
- Simultaneous reqs in the same arbitration cycle: exactly one gnt. The loser's req stays pending and is served next (loser starvation is impossible).
- A req arriving in ISSUE is not sampled until RESP.
- Reset asserted mid-transaction: the in-flight command is dropped immediately and asynchronously. No gnt or rvalid follows, and ram_we/ram_re fall to 0 without waiting for an edge.
- gnt and rvalid are never asserted to both masters in the same cycle.

## Test plan
- Single read m0: RAM[0x10]=0xDEADBEEF; m0_req=1, we=0, addr=0x10, be=4'hF at cycle 0.
  - Cycle 1: ram_re=1, ram_addr=0x10, m0_gnt=1.
  - Cycle 2: m0_rvalid=1, m0_rdata=0xDEADBEEF.
- Single byte write m1: addr=0x21, wdata=0x0000AB00, be=4'b0010.
  - Cycle 1: ram_we=1, ram_be=4'b0010, m1_gnt=1.
  - Cycle 2: m1_rvalid=1, m1_rdata=0.
  - Read-back of 0x20 returns byte 1 = 0xAB.
- Contention after reset: m0 and m1 both request at cycle 0.
  - m0_gnt at cycle 1, m1_gnt at cycle 3.
  - A second simultaneous pair is served m0 then m1 again, strictly alternating.
- Back-to-back m0: m0 keeps req high for 4 transactions.
  - gnt at cycles 1, 3, 5, 7; rvalid at cycles 2, 4, 6, 8.
  - ram_re never asserted in RESP.
- Reset in ISSUE: assert rst during the cycle ram_we=1.
  - ram_we=0 immediately, state IDLE, no rvalid.
  - After release, a new m1 request gets gnt (last_grant=1 restored, so m0 would win any contention).
- Idle: no reqs for 10 cycles → ram_we/ram_re/ram_be stay 0, no gnt/rvalid pulses.
